// File: rtl/fibo_datapath.sv
// Register file plus ALU that executes the Fibonacci controller's control word.
// Returns the registered zero/overflow status the controller branches on.
module fibo_datapath #(
    parameter int size       = 3,
    parameter int W          = 16,
    parameter int RESULT_REG = 3
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [size-2:0] wrt_addr,
    input  logic            wrt_en,
    input  logic            load_data,
    input  logic [size-2:0] rd_addr1,
    input  logic [size-2:0] rd_addr2,
    input  logic [size-1:0] alu_opcode,
    input  logic [W-1:0]    data_in,
    output logic            zero_flag,
    output logic            ovf_flag,
    output logic [W-1:0]    result,
    output logic [W-1:0]    alu_out
);

    localparam int NREG = 1 << (size - 1);

    typedef enum logic [size-1:0] {
        OP_PASS = 0,
        OP_ADD  = 1,
        OP_SUB  = 2,
        OP_INC  = 3,
        OP_DEC  = 4,
        OP_AND  = 5,
        OP_OR   = 6,
        OP_CLR  = 7
    } alu_op_e;

    logic [W-1:0] rf_q [NREG];
    logic         zero_q;
    logic         zero_d;
    logic         ovf_q;
    logic         ovf_d;

    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [W:0]   alu_ext;
    logic         alu_carry;
    logic [W-1:0] wd;

    assign opa = rf_q[rd_addr1];
    assign opb = rf_q[rd_addr2];

    // alu_ext carries the extra bit so carry and borrow fall out of bit W.
    always_comb begin
        alu_ext   = '0;
        alu_carry = 1'b0;
        case (alu_opcode)
            OP_PASS: alu_ext = {1'b0, opa};
            OP_ADD: begin
                alu_ext   = {1'b0, opa} + {1'b0, opb};
                alu_carry = alu_ext[W];
            end
            OP_SUB: begin
                alu_ext   = {1'b0, opa} - {1'b0, opb};
                alu_carry = alu_ext[W];
            end
            OP_INC: begin
                alu_ext   = {1'b0, opa} + {{W{1'b0}}, 1'b1};
                alu_carry = alu_ext[W];
            end
            OP_DEC: begin
                alu_ext   = {1'b0, opa} - {{W{1'b0}}, 1'b1};
                alu_carry = alu_ext[W];
            end
            OP_AND:  alu_ext = {1'b0, opa & opb};
            OP_OR:   alu_ext = {1'b0, opa | opb};
            OP_CLR:  alu_ext = '0;
            default: alu_ext = '0;
        endcase
    end

    assign alu_out = alu_ext[W-1:0];
    assign wd      = load_data ? data_in : alu_out;

    always_comb begin
        zero_d = zero_q;
        ovf_d  = ovf_q;
        if (wrt_en) begin
            zero_d = (wd == '0);
            if (load_data) begin
                ovf_d = 1'b0;
            end else if (alu_carry) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            zero_q <= 1'b1;
            ovf_q  <= 1'b0;
        end else begin
            if (wrt_en) begin
                rf_q[wrt_addr] <= wd;
            end
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign zero_flag = zero_q;
    assign ovf_flag  = ovf_q;
    assign result    = rf_q[RESULT_REG];

endmodule

// File: tb/tb_fibo_datapath.sv
// Directed bench for fibo_datapath: reset, countdown, Fibonacci,
// overflow, read-during-write and mid-operation reset.
module tb_fibo_datapath;

    localparam logic [2:0] PASS = 3'd0;
    localparam logic [2:0] ADD  = 3'd1;
    localparam logic [2:0] INC  = 3'd3;
    localparam logic [2:0] DEC  = 3'd4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [1:0]  wrt_addr;
    logic        wrt_en;
    logic        load_data;
    logic [1:0]  rd_addr1;
    logic [1:0]  rd_addr2;
    logic [2:0]  alu_opcode;
    logic [15:0] data_in;
    logic        zero_flag;
    logic        ovf_flag;
    logic [15:0] result;
    logic [15:0] alu_out;

    int checks   = 0;
    int failures = 0;

    fibo_datapath #(.size(3), .W(16), .RESULT_REG(3)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .wrt_addr   (wrt_addr),
        .wrt_en     (wrt_en),
        .load_data  (load_data),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .alu_opcode (alu_opcode),
        .data_in    (data_in),
        .zero_flag  (zero_flag),
        .ovf_flag   (ovf_flag),
        .result     (result),
        .alu_out    (alu_out)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic ld,
                         input logic [1:0] wa, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [2:0] op,
                         input logic [15:0] din);
        wrt_en     = we;
        load_data  = ld;
        wrt_addr   = wa;
        rd_addr1   = ra;
        rd_addr2   = rb;
        alu_opcode = op;
        data_in    = din;
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [1:0] wa, input logic [15:0] v);
        drive(1'b1, 1'b1, wa, 2'd0, 2'd0, PASS, v);
        tick();
    endtask

    task automatic alu(input logic [1:0] wa, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [2:0] op);
        drive(1'b1, 1'b0, wa, ra, rb, op, 16'h0);
        tick();
    endtask

    task automatic peek(input string tag, input logic [1:0] ra,
                        input logic [15:0] exp);
        drive(1'b0, 1'b0, 2'd0, ra, ra, PASS, 16'h0);
        #1;
        check(tag, alu_out, exp);
    endtask

    logic [15:0] fib_exp [6];

    initial begin
        fib_exp = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13};

        Rst = 1'b1;
        drive(1'b1, 1'b1, 2'd3, 2'd0, 2'd0, PASS, 16'h55);
        tick();
        tick();
        Rst = 1'b0;
        drive(1'b0, 1'b1, 2'd3, 2'd0, 2'd0, PASS, 16'hBEEF);
        #1;
        check("rst_result", result, 16'd0);
        check("rst_zero", {15'd0, zero_flag}, 16'd1);
        check("rst_ovf", {15'd0, ovf_flag}, 16'd0);

        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_result", result, 16'd0);
            check("idle_zero", {15'd0, zero_flag}, 16'd1);
        end
        check("idle_ovf", {15'd0, ovf_flag}, 16'd0);
        peek("idle_r0", 2'd0, 16'd0);
        peek("idle_r3", 2'd3, 16'd0);
        drive(1'b0, 1'b0, 2'd0, 2'd1, 2'd1, INC, 16'h0);
        #1;
        check("rst_alu_inc", alu_out, 16'd1);

        load(2'd0, 16'd5);
        check("ld5_zero", {15'd0, zero_flag}, 16'd0);
        for (int i = 0; i < 5; i++) begin
            alu(2'd0, 2'd0, 2'd0, DEC);
            check("dec_zero", {15'd0, zero_flag}, (i == 4) ? 16'd1 : 16'd0);
            peek("dec_r0", 2'd0, 16'(4 - i));
        end
        check("dec_ovf", {15'd0, ovf_flag}, 16'd0);

        load(2'd1, 16'd0);
        check("ld0_zero", {15'd0, zero_flag}, 16'd1);
        load(2'd2, 16'd1);
        for (int k = 0; k < 6; k++) begin
            alu(2'd3, 2'd1, 2'd2, ADD);
            check("fib_result", result, fib_exp[k]);
            alu(2'd1, 2'd2, 2'd0, PASS);
            alu(2'd2, 2'd3, 2'd0, PASS);
        end
        check("fib_ovf", {15'd0, ovf_flag}, 16'd0);

        load(2'd1, 16'hFFFF);
        check("ovf_ld_zero", {15'd0, zero_flag}, 16'd0);
        alu(2'd1, 2'd1, 2'd0, INC);
        check("inc_zero", {15'd0, zero_flag}, 16'd1);
        check("inc_ovf", {15'd0, ovf_flag}, 16'd1);
        peek("inc_r1", 2'd1, 16'd0);
        alu(2'd1, 2'd1, 2'd0, INC);
        check("sticky_ovf", {15'd0, ovf_flag}, 16'd1);
        check("sticky_zero", {15'd0, zero_flag}, 16'd0);
        load(2'd0, 16'd3);
        check("ldclr_ovf", {15'd0, ovf_flag}, 16'd0);

        load(2'd2, 16'd7);
        drive(1'b1, 1'b0, 2'd2, 2'd2, 2'd2, ADD, 16'h0);
        #1;
        check("rw_alu1", alu_out, 16'd14);
        tick();
        check("rw_alu2", alu_out, 16'd28);
        tick();
        peek("rw_r2", 2'd2, 16'd28);

        load(2'd3, 16'd4);
        check("pre_rst_result", result, 16'd4);
        load(2'd1, 16'hFFFF);
        alu(2'd1, 2'd1, 2'd0, INC);
        check("pre_rst_ovf", {15'd0, ovf_flag}, 16'd1);
        load(2'd1, 16'd6);
        Rst = 1'b1;
        drive(1'b1, 1'b1, 2'd3, 2'd0, 2'd0, PASS, 16'd9);
        tick();
        Rst = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, PASS, 16'h0);
        #1;
        check("mid_rst_result", result, 16'd0);
        check("mid_rst_zero", {15'd0, zero_flag}, 16'd1);
        check("mid_rst_ovf", {15'd0, ovf_flag}, 16'd0);
        peek("mid_rst_r1", 2'd1, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
